vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator and pixel output stage.
- Successor to the fixed 640x480 controller.
- Timing, sync polarity, colour depth and frame-buffer read latency are generics.
- Adds a data-enable output, frame/line start strobes, a vblank flag and a built-in test-pattern mode.
- Sits between the frame-buffer read port (col_addr/row_addr -> din) and the board VGA pins.

---
 rtl/vga_timing_gen.sv | 216 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-buffer address stage,
// read-latency matched control delay line and a colour/test-pattern output stage.
module vga_timing_gen #(
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned GRID_LOG2 = 5
) (
  input  logic                          vga_clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [3*COLOR_W-1:0]          din,
  output logic [$clog2(H_ACTIVE)-1:0]   col_addr,
  output logic [$clog2(V_ACTIVE)-1:0]   row_addr,
  output logic                          rd_en,
  output logic                          hs,
  output logic                          vs,
  output logic                          de,
  output logic                          vblank,
  output logic                          frame_start,
  output logic                          line_start,
  output logic [COLOR_W-1:0]            r,
  output logic [COLOR_W-1:0]            g,
  output logic [COLOR_W-1:0]            b
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACTIVE;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACTIVE;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned CW      = $clog2(H_ACTIVE);
  localparam int unsigned RW      = $clog2(V_ACTIVE);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned PW      = 3 * COLOR_W;
  localparam int unsigned G       = GRID_LOG2;
  // Delay-line word: hs, vs, de, vblank, line_start, frame_start, bar(3), col low, row low
  localparam int unsigned DW      = 9 + 2 * G;
  localparam logic [DW-1:0] DLY_RST = {!HS_POL, !VS_POL, 1'b0, 1'b1, 2'b00, 3'b000,
                                       {(2 * G){1'b0}}};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic          h_act, v_act, h_sync, v_sync, line_first;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;
  logic [CW-1:0] bar_px, bar_px_next;
  logic [2:0]    bar_k, bar_k_next;

  logic          hs_a, vs_a, vblank_a, ls_a, fs_a;

  logic [DW-1:0] a_vec;
  logic [DW-1:0] dly [RD_LAT];
  logic [DW-1:0] tap;

  logic          t_hs, t_vs, t_de, t_vb, t_ls, t_fs;
  logic [2:0]    t_k;
  logic [G-1:0]  t_col, t_row;

  logic [1:0]    mode_reg, mode_sel;
  logic [PW-1:0] pix;

  // Raster counters: h wraps every line, v advances on the last pixel of a line
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (32'(h_cnt) == H_TOTAL - 1) begin
      h_cnt <= '0;
      if (32'(v_cnt) == V_TOTAL - 1) v_cnt <= '0;
      else                           v_cnt <= v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Region decode, address arithmetic and colour-bar sub-counter next state
  always_comb begin
    h_act      = (32'(h_cnt) >= H_START) && (32'(h_cnt) < H_END);
    v_act      = (32'(v_cnt) >= V_START) && (32'(v_cnt) < V_END);
    h_sync     = 32'(h_cnt) < H_SYNC;
    v_sync     = 32'(v_cnt) < V_SYNC;
    line_first = 32'(h_cnt) == H_START;
    col_next   = CW'(h_cnt - HW'(H_START));
    row_next   = RW'(v_cnt - VW'(V_START));

    bar_px_next = bar_px;
    bar_k_next  = bar_k;
    if (line_first) begin
      bar_px_next = '0;
      bar_k_next  = '0;
    end else if (h_act) begin
      // The last bar absorbs the remainder pixels, so k saturates at 7
      if ((32'(bar_px) == BAR_W - 1) && (bar_k != 3'd7)) begin
        bar_px_next = '0;
        bar_k_next  = bar_k + 3'd1;
      end else begin
        bar_px_next = bar_px + 1'b1;
      end
    end
  end

  // Stage A: frame-buffer address plus raster flags, one cycle behind the counters
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      col_addr <= '0;
      row_addr <= '0;
      rd_en    <= 1'b0;
      hs_a     <= !HS_POL;
      vs_a     <= !VS_POL;
      vblank_a <= 1'b1;
      ls_a     <= 1'b0;
      fs_a     <= 1'b0;
      bar_px   <= '0;
      bar_k    <= '0;
    end else begin
      col_addr <= col_next;
      row_addr <= row_next;
      rd_en    <= h_act && v_act;
      hs_a     <= h_sync ? HS_POL : !HS_POL;
      vs_a     <= v_sync ? VS_POL : !VS_POL;
      vblank_a <= !v_act;
      ls_a     <= h_act && v_act && line_first;
      fs_a     <= h_act && v_act && line_first && (32'(v_cnt) == V_START);
      bar_px   <= bar_px_next;
      bar_k    <= bar_k_next;
    end
  end

  assign a_vec = {hs_a, vs_a, rd_en, vblank_a, ls_a, fs_a, bar_k,
                  col_addr[G-1:0], row_addr[G-1:0]};

  // Stage B: delay line matching the frame-buffer read latency
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= DLY_RST;
    end else begin
      dly[0] <= a_vec;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Unpack the delay-line tap and pick the mode in force for this pixel
  always_comb begin
    tap      = dly[RD_LAT-1];
    t_hs     = tap[DW-1];
    t_vs     = tap[DW-2];
    t_de     = tap[DW-3];
    t_vb     = tap[DW-4];
    t_ls     = tap[DW-5];
    t_fs     = tap[DW-6];
    t_k      = tap[DW-7 -: 3];
    t_col    = tap[2*G-1 -: G];
    t_row    = tap[G-1:0];
    // The new mode must already apply to the first pixel of the frame
    mode_sel = t_fs ? mode : mode_reg;
  end

  // Mode register, updated only at frame start so frames are never mixed
  always_ff @(posedge vga_clk) begin
    if (!rst)      mode_reg <= 2'b00;
    else if (t_fs) mode_reg <= mode;
  end

  // Colour select; blanking forces black regardless of mode
  always_comb begin
    pix = '0;
    if (t_de) begin
      unique case (mode_sel)
        2'b00: pix = din;
        2'b01: pix = {{COLOR_W{t_k[2]}}, {COLOR_W{t_k[1]}}, {COLOR_W{t_k[0]}}};
        2'b10: pix = ((t_col == '0) || (t_row == '0)) ? '1 : '0;
        2'b11: pix = '0;
      endcase
    end
  end

  // Output register: sync, strobes and colour leave together
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      hs          <= !HS_POL;
      vs          <= !VS_POL;
      de          <= 1'b0;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      hs          <= t_hs;
      vs          <= t_vs;
      de          <= t_de;
      vblank      <= t_vb;
      line_start  <= t_ls;
      frame_start <= t_fs;
      r           <= pix[COLOR_W-1:0];
      g           <= pix[2*COLOR_W-1:COLOR_W];
      b           <= pix[3*COLOR_W-1:2*COLOR_W];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (79x47) with RD_LAT=2.
module tb_vga_timing_gen;

  localparam int HS_W  = 4;
  localparam int HB    = 3;
  localparam int HA    = 70;
  localparam int HF    = 2;
  localparam int VS_W  = 2;
  localparam int VB    = 3;
  localparam int VA    = 40;
  localparam int VF    = 2;
  localparam int HT    = HS_W + HB + HA + HF;   // 79
  localparam int VT    = VS_W + VB + VA + VF;   // 47
  localparam int FR    = HT * VT;
  localparam int RDL   = 2;
  localparam int HST   = HS_W + HB;
  localparam int VST   = VS_W + VB;
  localparam int FIRST = VST * HT + HST + RDL + 2;  // 406

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [11:0] din;
  logic [11:0] d1;
  logic [6:0] col_addr;
  logic [5:0] row_addr;
  logic       rd_en, hs, vs, de, vblank, frame_start, line_start;
  logic [3:0] r, g, b;

  logic [11:0] pix_obs [VA][HA];
  int n_assert = 0;
  int n_fail   = 0;

  vga_timing_gen #(
    .H_SYNC(HS_W), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS_W), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .RD_LAT(RDL), .GRID_LOG2(3)
  ) dut (
    .vga_clk(clk), .rst(rst), .mode(mode), .din(din),
    .col_addr(col_addr), .row_addr(row_addr), .rd_en(rd_en),
    .hs(hs), .vs(vs), .de(de), .vblank(vblank),
    .frame_start(frame_start), .line_start(line_start),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: two-cycle read returning {row[3:0], col[7:0]}
  always @(posedge clk) begin
    d1  <= {row_addr[3:0], 1'b0, col_addr};
    din <= d1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic [1:0] m, input int c, input int rw);
    logic [2:0] kk;
    case (m)
      2'd0: return {4'(rw), 4'(c >> 4), 4'(c)};
      2'd1: begin
        kk = (c / 8 > 7) ? 3'd7 : 3'(c / 8);
        return {{4{kk[2]}}, {4{kk[1]}}, {4{kk[0]}}};
      end
      2'd2: return ((c % 8 == 0) || (rw % 8 == 0)) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  // Starting on the negedge where frame_start should be high, compare one whole frame
  task automatic scan_frame(input logic [1:0] em, input int sw_row, input logic [1:0] new_mode);
    int hs_low, vs_low, de_n, ls_n, fs_n, m_sync, m_ctl, m_addr, m_pix;
    hs_low = 0; vs_low = 0; de_n = 0; ls_n = 0; fs_n = 0;
    m_sync = 0; m_ctl = 0; m_addr = 0; m_pix = 0;
    for (int k = 0; k < FR; k++) begin
      int p, hc, vc, pa, hca, vca;
      logic e_de, e_rd;
      logic [11:0] e_pix;
      if (k == sw_row * HT) mode = new_mode;
      p  = k + VST * HT + HST;
      hc = p % HT;
      vc = (p / HT) % VT;
      e_de = (hc >= HST) && (hc < HST + HA) && (vc >= VST) && (vc < VST + VA);
      if (hs !== ((hc < HS_W) ? 1'b0 : 1'b1)) m_sync++;
      if (vs !== ((vc < VS_W) ? 1'b0 : 1'b1)) m_sync++;
      if (de !== e_de) m_ctl++;
      if (vblank !== !((vc >= VST) && (vc < VST + VA))) m_ctl++;
      if (line_start !== (e_de && hc == HST)) m_ctl++;
      if (frame_start !== (e_de && hc == HST && vc == VST)) m_ctl++;
      e_pix = e_de ? exp_pix(em, hc - HST, vc - VST) : 12'h000;
      if ({b, g, r} !== e_pix) m_pix++;
      if (e_de) pix_obs[vc - VST][hc - HST] = {b, g, r};
      pa  = p + RDL + 1;
      hca = pa % HT;
      vca = (pa / HT) % VT;
      e_rd = (hca >= HST) && (hca < HST + HA) && (vca >= VST) && (vca < VST + VA);
      if (rd_en !== e_rd) m_addr++;
      if (col_addr !== 7'(hca - HST)) m_addr++;
      if (row_addr !== 6'(vca - VST)) m_addr++;
      if (hs === 1'b0) hs_low++;
      if (vs === 1'b0) vs_low++;
      if (de === 1'b1) de_n++;
      if (line_start === 1'b1) ls_n++;
      if (frame_start === 1'b1) fs_n++;
      @(negedge clk);
    end
    check("hs_low_cycles", hs_low, HS_W * VT);
    check("vs_low_cycles", vs_low, VS_W * HT);
    check("de_cycles", de_n, HA * VA);
    check("line_start_count", ls_n, VA);
    check("frame_start_count", fs_n, 1);
    check("sync_mismatches", m_sync, 0);
    check("ctl_mismatches", m_ctl, 0);
    check("addr_mismatches", m_addr, 0);
    check("pixel_mismatches", m_pix, 0);
    check("next_frame_start", frame_start, 1'b1);
  endtask

  task automatic wait_frame_start(input string tag);
    int cnt, de_pre;
    bit seen;
    cnt = 0; de_pre = 0; seen = 0;
    while (!seen && cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (frame_start === 1'b1) seen = 1;
      else if (de === 1'b1) de_pre++;
    end
    check({tag, "_latency"}, cnt, FIRST);
    check({tag, "_no_partial_de"}, de_pre, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, hs, 1'b1);
    check({tag, "_vs"}, vs, 1'b1);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_vblank"}, vblank, 1'b1);
    check({tag, "_rgb"}, {b, g, r}, 12'h000);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_strobes"}, {frame_start, line_start}, 2'b00);
    check({tag, "_addr"}, {col_addr, row_addr}, 13'h0);
  endtask

  initial begin
    rst  = 1'b0;
    mode = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_frame_start("release");
    check("first_pixel_strobes", {frame_start, line_start, de}, 3'b111);
    check("first_pixel_rgb", {b, g, r}, 12'h000);

    // Passthrough; request colour bars mid-frame
    scan_frame(2'd0, 20, 2'd1);
    check("pt_pix_5_3", pix_obs[3][5], 12'h305);
    check("pt_pix_69_39", pix_obs[39][69], 12'h745);

    // Colour bars (last bar is 14 pixels wide); request grid mid-frame
    scan_frame(2'd1, 20, 2'd2);
    check("bar_col0", pix_obs[10][0], 12'h000);
    check("bar_col8", pix_obs[10][8], 12'h00F);
    check("bar_col55", pix_obs[10][55], 12'hFF0);
    check("bar_col56", pix_obs[10][56], 12'hFFF);
    check("bar_col69", pix_obs[10][69], 12'hFFF);

    // Grid; request black mid-frame
    scan_frame(2'd2, 20, 2'd3);
    check("grid_0_1", pix_obs[1][0], 12'hFFF);
    check("grid_1_1", pix_obs[1][1], 12'h000);
    check("grid_8_5", pix_obs[5][8], 12'hFFF);
    check("grid_1_8", pix_obs[8][1], 12'hFFF);
    check("grid_9_9", pix_obs[9][9], 12'h000);

    // Black; request colour bars for after the reset
    scan_frame(2'd3, 20, 2'd1);
    check("black_8_8", pix_obs[8][8], 12'h000);

    // Mid-frame single-cycle reset
    repeat (20 * HT + 30) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b1;
    wait_frame_start("rerelease");
    scan_frame(2'd1, -1, 2'd1);
    check("post_reset_bar_col8", pix_obs[10][8], 12'h00F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
